// File: rtl/uart_tx_serializer_if.sv
// TX FIFO read port between the upstream FIFO and the UART serializer.
// Read data is valid two clocks after the active-low pop strobe.
interface uart_tx_serializer_if;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_read_n;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_read_n
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_read_n
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops one byte per frame from a TX FIFO and
// shifts start, 7/8 data bits LSB first, optional parity and stop bit.
module uart_tx_serializer #(
   parameter bit SYNC_RESET    = 1'b0,
   parameter int TICKS_PER_BIT = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 baud_clock,
   input  logic                 bit8,
   input  logic                 parity_en,
   input  logic                 odd_n_even,
   uart_tx_serializer_if.master fifo,
   output logic                 tx,
   output logic                 tx_busy
);

   localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT1,
      WAIT2,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] hold_q, hold_d;
   logic [3:0] tick_q, tick_d;
   logic [2:0] idx_q, idx_d;
   logic       bit8_q, bit8_d;
   logic       par_en_q, par_en_d;
   logic       odd_q, odd_d;
   logic       armed_q;
   logic       tx_q, tx_d;
   logic       rd_n_q, rd_n_d;
   logic       busy_q, busy_d;

   logic       arst_n;
   logic       srst;
   logic       in_frame;
   logic       bit_end;
   logic       last_idx;
   logic       parity;

   // One reset net feeds the async list, the other the sync branch.
   assign arst_n = SYNC_RESET ? 1'b1 : reset_n;
   assign srst   = SYNC_RESET ? ~reset_n : 1'b0;

   assign in_frame = (state_q == START) || (state_q == DATA) ||
                     (state_q == PARITY) || (state_q == STOP);
   assign bit_end  = baud_clock && (tick_q == TICK_LAST);
   assign last_idx = (idx_q == (bit8_q ? 3'd7 : 3'd6));
   assign parity   = (bit8_q ? ^hold_q : ^hold_q[6:0]) ^ odd_q;

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      tick_d   = tick_q;
      idx_d    = idx_q;
      bit8_d   = bit8_q;
      par_en_d = par_en_q;
      odd_d    = odd_q;

      if (in_frame && baud_clock) begin
         tick_d = bit_end ? 4'd0 : tick_q + 4'd1;
      end

      unique case (state_q)
         IDLE: begin
            if (armed_q && !fifo.fifo_empty) begin
               state_d = FETCH;
            end
         end
         FETCH: state_d = WAIT1;
         WAIT1: state_d = WAIT2;
         WAIT2: begin
            state_d  = START;
            hold_d   = fifo.fifo_data;
            tick_d   = 4'd0;
            bit8_d   = bit8;
            par_en_d = parity_en;
            odd_d    = odd_n_even;
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = 3'd0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (last_idx) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = fifo.fifo_empty ? IDLE : FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register in step.
   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = hold_d[idx_d];
         PARITY:  tx_d = parity;
         default: tx_d = 1'b1;
      endcase
      rd_n_d = (state_d != FETCH);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge arst_n) begin
      if (!arst_n) begin
         state_q  <= IDLE;
         hold_q   <= 8'h00;
         tick_q   <= 4'd0;
         idx_q    <= 3'd0;
         bit8_q   <= 1'b1;
         par_en_q <= 1'b0;
         odd_q    <= 1'b0;
         armed_q  <= 1'b0;
         tx_q     <= 1'b1;
         rd_n_q   <= 1'b1;
         busy_q   <= 1'b0;
      end else if (srst) begin
         state_q  <= IDLE;
         hold_q   <= 8'h00;
         tick_q   <= 4'd0;
         idx_q    <= 3'd0;
         bit8_q   <= 1'b1;
         par_en_q <= 1'b0;
         odd_q    <= 1'b0;
         armed_q  <= 1'b0;
         tx_q     <= 1'b1;
         rd_n_q   <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         hold_q   <= hold_d;
         tick_q   <= tick_d;
         idx_q    <= idx_d;
         bit8_q   <= bit8_d;
         par_en_q <= par_en_d;
         odd_q    <= odd_d;
         armed_q  <= 1'b1;
         tx_q     <= tx_d;
         rd_n_q   <= rd_n_d;
         busy_q   <= busy_d;
      end
   end

   assign tx               = tx_q;
   assign tx_busy          = busy_q;
   assign fifo.fifo_read_n = rd_n_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: a FIFO model feeds bytes,
// a tick-aligned line monitor captures frames for comparison.
module tb_uart_tx_serializer;
   localparam int TPB  = 16;
   localparam int BDIV = 2;

   typedef struct {
      int          nbits;
      logic [10:0] bits;
      bit          width_ok;
      int          gap;
   } frame_t;

   logic clock      = 1'b0;
   logic reset_n    = 1'b0;
   logic baud_clock = 1'b0;
   logic bit8       = 1'b1;
   logic parity_en  = 1'b0;
   logic odd_n_even = 1'b0;
   logic tx;
   logic tx_busy;

   uart_tx_serializer_if fifo_if ();

   uart_tx_serializer #(
      .SYNC_RESET   (1'b0),
      .TICKS_PER_BIT(TPB)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .baud_clock(baud_clock),
      .bit8      (bit8),
      .parity_en (parity_en),
      .odd_n_even(odd_n_even),
      .fifo      (fifo_if),
      .tx        (tx),
      .tx_busy   (tx_busy)
   );

   int         n_run = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         bcnt = 0;
   int         rd_pulses = 0;
   int         rd_when_empty = 0;
   logic [7:0] stage1 = 8'h00;
   logic [7:0] fifo_q[$];
   frame_t     exp_q[$];
   frame_t     obs_q[$];
   bit         mon_active = 1'b0;
   int         mon_bit = 0;
   int         tx_low_cnt = 0;
   int         last_stop_cyc = -1000;

   always #5 clock = ~clock;

   // FIFO model: pop on the strobe, data appears two clocks later.
   always @(posedge clock) begin
      cyc        <= cyc + 1;
      bcnt       <= (bcnt == BDIV - 1) ? 0 : bcnt + 1;
      baud_clock <= (bcnt == BDIV - 1);
      if (fifo_if.fifo_read_n === 1'b0) begin
         rd_pulses <= rd_pulses + 1;
         if (fifo_if.fifo_empty === 1'b1) rd_when_empty <= rd_when_empty + 1;
         if (fifo_q.size() > 0) stage1 <= fifo_q.pop_front();
      end
      fifo_if.fifo_data  <= stage1;
      fifo_if.fifo_empty <= (fifo_q.size() == 0);
   end

   initial begin : monitor
      frame_t f;
      int     ticks;
      int     k;
      int     ph;
      int     nb;
      logic   first;
      f = '{nbits: 0, bits: '1, width_ok: 1'b1, gap: 0};
      ticks = 0;
      nb = 11;
      first = 1'b1;
      forever begin
         @(negedge clock);
         if (reset_n !== 1'b1) begin
            mon_active = 1'b0;
            continue;
         end
         if (tx === 1'b0) tx_low_cnt++;
         if (!mon_active && tx === 1'b0) begin
            mon_active = 1'b1;
            ticks = 0;
            mon_bit = 0;
            nb = (exp_q.size() > 0) ? exp_q[0].nbits : 11;
            f.nbits = nb;
            f.bits = '1;
            f.width_ok = 1'b1;
            f.gap = cyc - last_stop_cyc;
         end
         if (mon_active && baud_clock === 1'b1) begin
            ticks++;
            k = (ticks - 1) / TPB;
            ph = (ticks - 1) % TPB;
            mon_bit = k;
            if (ph == 0) first = tx;
            if (ph == TPB / 2) f.bits[k] = tx;
            if (ph == TPB - 1) begin
               if (tx !== first) f.width_ok = 1'b0;
               if (k == nb - 1) begin
                  obs_q.push_back(f);
                  mon_active = 1'b0;
                  last_stop_cyc = cyc + 1;
               end
            end
         end
      end
   end

   function automatic frame_t frame_of(input logic [7:0] d, input logic b8,
                                       input logic pe, input logic odd);
      frame_t f;
      int     n;
      logic   p;
      f.bits = '1;
      f.bits[0] = 1'b0;
      f.width_ok = 1'b1;
      f.gap = 0;
      n = 1;
      p = odd;
      for (int i = 0; i < (b8 ? 8 : 7); i++) begin
         f.bits[n] = d[i];
         p = p ^ d[i];
         n++;
      end
      if (pe) begin
         f.bits[n] = p;
         n++;
      end
      f.bits[n] = 1'b1;
      f.nbits = n + 1;
      return f;
   endfunction

   task automatic wait_frames(input int n, input int budget);
      for (int i = 0; i < budget && obs_q.size() < n; i++) begin
         @(negedge clock);
         #1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      n_run++;
      if (tx !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_tx: got %b want 1", tx);
      end
      n_run++;
      if (fifo_if.fifo_read_n !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_read_n: got %b want 1", fifo_if.fifo_read_n);
      end
      n_run++;
      if (tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b want 0", tx_busy);
      end
   endtask

   task automatic test_8n1();
      frame_t      e, o;
      logic [10:0] m;
      int          p0, t0;
      bit8 = 1'b1;
      parity_en = 1'b0;
      odd_n_even = 1'b0;
      fifo_q.push_back(8'h55);
      exp_q.push_back(frame_of(8'h55, 1'b1, 1'b0, 1'b0));
      p0 = rd_pulses;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      n_run++;
      if (fifo_if.fifo_read_n !== 1'b1) begin
         n_fail++;
         $display("FAIL first_fetch_early: read_n %b want 1", fifo_if.fifo_read_n);
      end
      @(negedge clock);
      n_run++;
      if (fifo_if.fifo_read_n !== 1'b0 || tx_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL first_fetch: read_n %b busy %b want 0 1",
                  fifo_if.fifo_read_n, tx_busy);
      end
      wait_frames(1, 1000);
      n_run++;
      if (obs_q.size() != 1) begin
         n_fail++;
         $display("FAIL 8n1_count: got %0d frames want 1", obs_q.size());
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         m = 11'h7FF >> (11 - e.nbits);
         n_run++;
         if ((o.bits & m) !== (e.bits & m)) begin
            n_fail++;
            $display("FAIL 8n1_bits: got %b want %b", o.bits & m, e.bits & m);
         end
         n_run++;
         if (!o.width_ok) begin
            n_fail++;
            $display("FAIL 8n1_width: a bit was not %0d ticks wide", TPB);
         end
      end
      n_run++;
      if (tx_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL 8n1_busy_stop: got %b want 1 during stop", tx_busy);
      end
      @(negedge clock);
      n_run++;
      if (tx_busy !== 1'b0 || tx !== 1'b1) begin
         n_fail++;
         $display("FAIL 8n1_after: busy %b tx %b want 0 1", tx_busy, tx);
      end
      t0 = tx_low_cnt;
      repeat (100) @(negedge clock);
      n_run++;
      if (rd_pulses - p0 != 1 || tx_low_cnt != t0) begin
         n_fail++;
         $display("FAIL 8n1_idle: pulses %0d low %0d want 1 0",
                  rd_pulses - p0, tx_low_cnt - t0);
      end
      exp_q.delete();
   endtask

   task automatic test_parity_even();
      frame_t      e, o;
      logic [10:0] m;
      bit8 = 1'b1;
      parity_en = 1'b1;
      odd_n_even = 1'b0;
      fifo_q.push_back(8'hA3);
      exp_q.push_back(frame_of(8'hA3, 1'b1, 1'b1, 1'b0));
      wait_frames(1, 1000);
      n_run++;
      if (obs_q.size() != 1) begin
         n_fail++;
         $display("FAIL par_even_count: got %0d frames want 1", obs_q.size());
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         m = 11'h7FF >> (11 - e.nbits);
         n_run++;
         if ((o.bits & m) !== (e.bits & m)) begin
            n_fail++;
            $display("FAIL par_even_bits: got %b want %b", o.bits & m, e.bits & m);
         end
      end
      repeat (20) @(negedge clock);
      exp_q.delete();
   endtask

   task automatic test_7bit_odd();
      frame_t      e, o;
      logic [10:0] m;
      bit8 = 1'b0;
      parity_en = 1'b1;
      odd_n_even = 1'b1;
      fifo_q.push_back(8'hFF);
      exp_q.push_back(frame_of(8'hFF, 1'b0, 1'b1, 1'b1));
      for (int i = 0; i < 200 && !mon_active; i++) begin
         @(negedge clock);
         #1;
      end
      bit8 = 1'b1;
      parity_en = 1'b0;
      odd_n_even = 1'b0;
      wait_frames(1, 1000);
      n_run++;
      if (obs_q.size() != 1) begin
         n_fail++;
         $display("FAIL b7_odd_count: got %0d frames want 1", obs_q.size());
      end else begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         m = 11'h7FF >> (11 - e.nbits);
         n_run++;
         if ((o.bits & m) !== (e.bits & m) || !o.width_ok) begin
            n_fail++;
            $display("FAIL b7_odd_bits: got %b want %b width %b",
                     o.bits & m, e.bits & m, o.width_ok);
         end
      end
      repeat (20) @(negedge clock);
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      frame_t      e, o;
      logic [10:0] m;
      logic [7:0]  data [3];
      int          p0;
      data[0] = 8'h12;
      data[1] = 8'h34;
      data[2] = 8'hC5;
      bit8 = 1'b1;
      parity_en = 1'b0;
      odd_n_even = 1'b0;
      p0 = rd_pulses;
      for (int i = 0; i < 3; i++) begin
         fifo_q.push_back(data[i]);
         exp_q.push_back(frame_of(data[i], 1'b1, 1'b0, 1'b0));
      end
      wait_frames(3, 2500);
      n_run++;
      if (obs_q.size() != 3) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d frames want 3", obs_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            m = 11'h7FF >> (11 - e.nbits);
            n_run++;
            if ((o.bits & m) !== (e.bits & m)) begin
               n_fail++;
               $display("FAIL b2b_bits%0d: got %b want %b", i, o.bits & m, e.bits & m);
            end
            if (i > 0) begin
               n_run++;
               if (o.gap != 3) begin
                  n_fail++;
                  $display("FAIL b2b_gap%0d: got %0d clocks want 3", i, o.gap);
               end
            end
         end
      end
      repeat (20) @(negedge clock);
      n_run++;
      if (rd_pulses - p0 != 3) begin
         n_fail++;
         $display("FAIL b2b_pulses: got %0d want 3", rd_pulses - p0);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_frame();
      int p0, t0;
      bit8 = 1'b1;
      parity_en = 1'b0;
      fifo_q.push_back(8'h5A);
      for (int i = 0; i < 1000 && !(mon_active && mon_bit == 5); i++) begin
         @(negedge clock);
         #1;
      end
      n_run++;
      if (!(mon_active && mon_bit == 5)) begin
         n_fail++;
         $display("FAIL midrst_reach: bit %0d active %b want data bit 4", mon_bit, mon_active);
      end
      reset_n = 1'b0;
      #1;
      n_run++;
      if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_if.fifo_read_n !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_outputs: tx %b busy %b read_n %b want 1 0 1",
                  tx, tx_busy, fifo_if.fifo_read_n);
      end
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      p0 = rd_pulses;
      t0 = tx_low_cnt;
      repeat (1000) @(negedge clock);
      n_run++;
      if (obs_q.size() != 0 || rd_pulses != p0 || tx_low_cnt != t0) begin
         n_fail++;
         $display("FAIL midrst_quiet: frames %0d pulses %0d low %0d want 0 0 0",
                  obs_q.size(), rd_pulses - p0, tx_low_cnt - t0);
      end
      obs_q.delete();
   endtask

   task automatic test_idle_empty();
      int p0, t0;
      p0 = rd_pulses;
      t0 = tx_low_cnt;
      repeat (1000) @(negedge clock);
      n_run++;
      if (rd_pulses != p0) begin
         n_fail++;
         $display("FAIL idle_pulses: got %0d want 0", rd_pulses - p0);
      end
      n_run++;
      if (tx_low_cnt != t0 || tx !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_tx: low %0d tx %b want 0 1", tx_low_cnt - t0, tx);
      end
      n_run++;
      if (rd_when_empty != 0) begin
         n_fail++;
         $display("FAIL read_when_empty: got %0d want 0", rd_when_empty);
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity_even();
      test_7bit_odd();
      test_back_to_back();
      test_reset_mid_frame();
      test_idle_empty();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 Parameter SYNC_RESET, 0: 1 = reset_n acts synchronously (build-time option); 0 = asynchronous, active-low.
REQ-002 Parameter TICKS_PER_BIT, 16: baud_clock ticks per serial bit; legal range 2-16.
REQ-003 clock  in  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 baud_clock  in  1  one-clock-wide enable pulse at TICKS_PER_BIT x baud rate.
REQ-006 bit8  in  1  1 = 8 data bits; 0 = 7 data bits (fifo_data[7] ignored).
REQ-007 parity_en  in  1  1 = append parity bit.
REQ-008 odd_n_even  in  1  1 = odd parity; 0 = even parity.
REQ-009 fifo_empty  in  1  empty flag from upstream TX FIFO.
REQ-010 fifo_data  in  8  TX FIFO read data; valid 2 clocks after fifo_read_n low.
REQ-011 fifo_read_n  out  1  active-low FIFO pop strobe.
REQ-012 tx  out  1  serial line, idle high.
REQ-013 tx_busy  out  1  high from FETCH entry until STOP completes.

Function
REQ-014 States: IDLE, FETCH, WAIT1, WAIT2, START, DATA, PARITY, STOP; one-hot or binary is free.
REQ-015 IDLE -> FETCH on the first clock where fifo_empty=0; otherwise remain in IDLE.
REQ-016 fifo_read_n SHALL be low for exactly one clock, the FETCH cycle; high in every other state.
REQ-017 FETCH -> WAIT1 -> WAIT2 unconditionally, one clock each; the edge leaving WAIT2 captures fifo_data into an 8-bit hold register.
REQ-018 WAIT2 -> START; the bit-tick counter clears on START entry.
REQ-019 Bit-tick counter: 4 bits, increments only on baud_clock=1; bit period ends on the tick where counter = TICKS_PER_BIT-1, and the counter wraps to 0 there.
REQ-020 START drives tx=0 for one bit period, then -> DATA with bit index 0.
REQ-021 DATA drives tx = hold[index], LSB first; index increments at each bit period end.
REQ-022 Leave DATA after index 7 (bit8=1) or index 6 (bit8=0); go to PARITY if parity_en=1, else STOP.
REQ-023 PARITY drives tx = XOR of the transmitted data bits XOR odd_n_even for one bit period, then -> STOP.
REQ-024 STOP drives tx=1 for one bit period, then -> FETCH if fifo_empty=0 (back-to-back, no idle gap beyond 3 clocks), else IDLE.
REQ-025 bit8, parity_en and odd_n_even are sampled into the frame on START entry; changes mid-frame do not affect the current frame.
REQ-026 tx is registered; no combinational path from any input to tx or fifo_read_n.
REQ-027 baud_clock pulses in FETCH/WAIT1/WAIT2/IDLE are ignored.
REQ-028 fifo_empty going high after FETCH does not abort the frame; the fetched byte is always sent.
REQ-029 The block never asserts fifo_read_n while fifo_empty=1.

Reset
REQ-030 On reset: state=IDLE, tx=1, fifo_read_n=1, tx_busy=0, hold=0x00, counter=0, index=0.
REQ-031 Reset asserted mid-frame aborts immediately; tx returns to 1 the same cycle (async) or next edge (SYNC_RESET=1); the partial byte is discarded.
REQ-032 After reset release, the first FETCH occurs no earlier than the second clock edge.

Verification
REQ-033 FIFO holds 0x55, 8N1, TICKS_PER_BIT=16 -> one fifo_read_n low pulse; tx = 0,1,0,1,0,1,0,1,0,1 each 16 ticks, then idle high; tx_busy falls after stop bit.
REQ-034 0xA3, bit8=1, parity_en=1, odd_n_even=0 -> data bits 1,1,0,0,0,1,0,1, parity bit 0, stop bit 1.
REQ-035 0xFF, bit8=0, parity_en=1, odd_n_even=1 -> 7 data ones, parity bit 0, 10-bit frame total.
REQ-036 FIFO holds 3 bytes -> 3 frames; each new start bit begins exactly 3 clocks after the previous stop bit ends; exactly 3 fifo_read_n pulses.
REQ-037 reset_n low during DATA bit 4 -> tx=1, tx_busy=0, fifo_read_n=1; with FIFO empty, nothing further is transmitted after release.
REQ-038 fifo_empty=1 held for 1000 clocks with baud_clock toggling -> fifo_read_n never low, tx constant 1.
